// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
//   Shared definitions for the branch prediction / resolution unit:
//     OPC_BRANCH  - RV32 conditional-branch major opcode
//     br_funct3_e - funct3 encodings of the six conditional branches
//     pc_sel_e    - next-PC redirect selector driven by br_pred_unit
//     ctr_init()  - reset value of a CNT_W-bit counter (weakly not-taken)
// ---------------------------------------------------------------------------
package br_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic [1:0] {
        PC_SEL_NONE = 2'b00,  // keep fetching sequentially
        PC_SEL_ALU  = 2'b01,  // redirect to the ALU-computed branch target
        PC_SEL_PC4  = 2'b10   // redirect to the fall-through PC (pc_E + 4)
    } pc_sel_e;

    // Largest value that still has MSB clear: 2^(w-1)-1.
    function automatic int unsigned ctr_init(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/br_bht.sv
// ---------------------------------------------------------------------------
// br_bht
//   Branch history table: BHT_DEPTH saturating counters of CNT_W bits.
//   All counters reset asynchronously to the weakly-not-taken value.
//   The read port is purely combinational from the registered array, so a
//   same-cycle read and update of one entry returns the pre-update value.
//
// Ports
//   i_clk        clock, updates on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rd_idx     lookup index
//   o_rd_msb     MSB of the looked-up counter (predict taken)
//   i_upd_en     apply one increment/decrement this cycle
//   i_upd_idx    index of the counter to update
//   i_upd_taken  1: increment (saturate high), 0: decrement (saturate at 0)
// ---------------------------------------------------------------------------
module br_bht
    import br_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_msb,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    localparam logic [CNT_W-1:0] CTR_RST = CNT_W'(ctr_init(CNT_W));
    localparam logic [CNT_W-1:0] CTR_MAX = '1;

    logic [CNT_W-1:0] cnt_q [BHT_DEPTH];
    logic [CNT_W-1:0] cnt_d;

    // Next value of the single entry being updated.
    always_comb begin
        cnt_d = cnt_q[i_upd_idx];
        if (i_upd_taken) begin
            if (cnt_q[i_upd_idx] != CTR_MAX) begin
                cnt_d = cnt_q[i_upd_idx] + CNT_W'(1);
            end
        end else begin
            if (cnt_q[i_upd_idx] != '0) begin
                cnt_d = cnt_q[i_upd_idx] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= CTR_RST;
            end
        end else if (i_upd_en) begin
            cnt_q[i_upd_idx] <= cnt_d;
        end
    end

    assign o_rd_msb = cnt_q[i_rd_idx][CNT_W-1];

endmodule

// File: rtl/br_pred_unit.sv
// ---------------------------------------------------------------------------
// br_pred_unit
//   Fetch-stage direction predictor plus execute-stage branch resolution.
//   The E-side decode/resolve path is purely combinational; the only state
//   is the BHT (in br_bht) and the optional performance counters.
//
//   Optional feature: define BR_PERF_CNT_EN to add the 32-bit saturating
//   o_br_cnt / o_mispred_cnt counters. Without it those ports do not exist.
//
// Ports
//   i_clk, i_rst_n    clock / asynchronous active-low reset
//   i_pc_F            fetch PC, indexes the BHT
//   o_pred_taken_F    predicted direction for i_pc_F
//   i_instr_E, i_pc_E execute-stage instruction and its PC
//   i_pred_taken_E    prediction that travelled with i_instr_E
//   i_br_less/equal   comparator results for the E operands
//   i_stall_E         E held this cycle: no BHT update, no counting
//   i_kill_E          E squashed: behaves as a non-branch
//   o_ctr_opa_sel_E   E holds a valid conditional branch
//   o_br_unsigned_E   comparator unsigned select (funct3[1] of a branch)
//   o_opa_sel         branch resolved taken (ALU opA = PC for target)
//   o_pc_sel          redirect select (see br_pkg::pc_sel_e)
//   o_mispredict_E    resolved direction differs from i_pred_taken_E
//   o_br_cnt          [BR_PERF_CNT_EN] valid unstalled branches
//   o_mispred_cnt     [BR_PERF_CNT_EN] mispredicted unstalled branches
// ---------------------------------------------------------------------------
module br_pred_unit
    import br_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int XLEN      = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc_F,
    output logic            o_pred_taken_F,
    input  logic [XLEN-1:0] i_instr_E,
    input  logic [XLEN-1:0] i_pc_E,
    input  logic            i_pred_taken_E,
    input  logic            i_br_less,
    input  logic            i_br_equal,
    input  logic            i_stall_E,
    input  logic            i_kill_E,
    output logic            o_ctr_opa_sel_E,
    output logic            o_br_unsigned_E,
    output logic            o_opa_sel,
    output logic [1:0]      o_pc_sel,
    output logic            o_mispredict_E
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]     o_br_cnt,
    output logic [31:0]     o_mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_cond;
    logic             taken;
    logic             valid;
    logic             mispredict;
    logic             upd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;

    assign opcode = i_instr_E[6:0];
    assign funct3 = i_instr_E[14:12];

    // funct3 010/011 fall to the default arm and are not branches.
    always_comb begin
        is_cond = 1'b0;
        taken   = 1'b0;
        case (funct3)
            F3_BEQ:  begin is_cond = 1'b1; taken = i_br_equal;  end
            F3_BNE:  begin is_cond = 1'b1; taken = !i_br_equal; end
            F3_BLT:  begin is_cond = 1'b1; taken = i_br_less;   end
            F3_BGE:  begin is_cond = 1'b1; taken = !i_br_less;  end
            F3_BLTU: begin is_cond = 1'b1; taken = i_br_less;   end
            F3_BGEU: begin is_cond = 1'b1; taken = !i_br_less;  end
            default: begin is_cond = 1'b0; taken = 1'b0;        end
        endcase
    end

    assign valid      = (opcode == OPC_BRANCH) && is_cond && !i_kill_E;
    assign mispredict = valid && (taken != i_pred_taken_E);
    assign upd_en     = valid && !i_stall_E;

    always_comb begin
        o_ctr_opa_sel_E = valid;
        o_br_unsigned_E = valid && funct3[1];
        o_opa_sel       = valid && taken;
        o_mispredict_E  = mispredict;
        o_pc_sel        = PC_SEL_NONE;
        if (mispredict) begin
            o_pc_sel = taken ? PC_SEL_ALU : PC_SEL_PC4;
        end
    end

    // Word-aligned PCs: drop the two byte-offset bits.
    assign rd_idx  = i_pc_F[IDX_W+1:2];
    assign upd_idx = i_pc_E[IDX_W+1:2];

    br_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W)
    ) u_bht (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_idx    (rd_idx),
        .o_rd_msb    (o_pred_taken_F),
        .i_upd_en    (upd_en),
        .i_upd_idx   (upd_idx),
        .i_upd_taken (taken)
    );

    // Instruction/PC bits that play no part in prediction or resolution.
    logic unused_bits;
    assign unused_bits = ^{i_instr_E[XLEN-1:15], i_instr_E[11:7],
                           i_pc_F[XLEN-1:IDX_W+2], i_pc_F[1:0],
                           i_pc_E[XLEN-1:IDX_W+2], i_pc_E[1:0]};

`ifdef BR_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (upd_en && mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_br_pred_unit.sv
// Directed testbench for br_pred_unit (default parameters: 64 entries, 2-bit
// counters, XLEN 32). Inputs change on the falling edge; outputs are sampled
// 1 time unit later, well away from the rising edge.
module tb_br_pred_unit;

  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_pc_F;
  logic        o_pred_taken_F;
  logic [31:0] i_instr_E;
  logic [31:0] i_pc_E;
  logic        i_pred_taken_E;
  logic        i_br_less;
  logic        i_br_equal;
  logic        i_stall_E;
  logic        i_kill_E;
  logic        o_ctr_opa_sel_E;
  logic        o_br_unsigned_E;
  logic        o_opa_sel;
  logic [1:0]  o_pc_sel;
  logic        o_mispredict_E;
`ifdef BR_PERF_CNT_EN
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  br_pred_unit dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_pc_F          (i_pc_F),
    .o_pred_taken_F  (o_pred_taken_F),
    .i_instr_E       (i_instr_E),
    .i_pc_E          (i_pc_E),
    .i_pred_taken_E  (i_pred_taken_E),
    .i_br_less       (i_br_less),
    .i_br_equal      (i_br_equal),
    .i_stall_E       (i_stall_E),
    .i_kill_E        (i_kill_E),
    .o_ctr_opa_sel_E (o_ctr_opa_sel_E),
    .o_br_unsigned_E (o_br_unsigned_E),
    .o_opa_sel       (o_opa_sel),
    .o_pc_sel        (o_pc_sel),
    .o_mispredict_E  (o_mispredict_E)
`ifdef BR_PERF_CNT_EN
    ,
    .o_br_cnt        (o_br_cnt),
    .o_mispred_cnt   (o_mispred_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // ---------------- drivers ----------------
  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    return {17'h0, f3, 5'h0, opc};
  endfunction

  task automatic drive_e(input logic [31:0] instr, input logic [31:0] pc,
                         input logic eq, input logic lt, input logic pred,
                         input logic stall, input logic kill);
    i_instr_E      = instr;
    i_pc_E         = pc;
    i_br_equal     = eq;
    i_br_less      = lt;
    i_pred_taken_E = pred;
    i_stall_E      = stall;
    i_kill_E       = kill;
  endtask

  task automatic idle_e();
    drive_e(NOP, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] pcs [4];
    pcs = '{32'h0, 32'h4, 32'h100, 32'hFC};
    @(negedge i_clk);
    i_rst_n = 1'b0;
    idle_e();
    for (int k = 0; k < 4; k++) begin
      i_pc_F = pcs[k];
      #1;
      checks++;
      if (o_pred_taken_F !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred pc=%h got=%b exp=0", pcs[k], o_pred_taken_F);
      end
    end
    // E side stays live during reset.
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_mispredict_E !== 1'b1 || o_pc_sel !== 2'b01) begin
      failures++;
      $display("FAIL reset_e_live got misp=%b pc_sel=%b exp misp=1 pc_sel=01",
               o_mispredict_E, o_pc_sel);
    end
    idle_e();
    #1;
    checks++;
    if ({o_ctr_opa_sel_E, o_br_unsigned_E, o_opa_sel, o_pc_sel, o_mispredict_E} !== 6'b0) begin
      failures++;
      $display("FAIL reset_e_idle got=%b exp=000000",
               {o_ctr_opa_sel_E, o_br_unsigned_E, o_opa_sel, o_pc_sel, o_mispredict_E});
    end
`ifdef BR_PERF_CNT_EN
    checks++;
    if (o_br_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got br=%0d misp=%0d exp 0/0", o_br_cnt, o_mispred_cnt);
    end
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_pc_F = 32'h40;
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_pred got=%b exp=0", o_pred_taken_F);
    end
  endtask

  task automatic test_beq_mispredict();
    apply_reset();
    @(negedge i_clk);
    i_pc_F = 32'h100;
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if ({o_pred_taken_F, o_ctr_opa_sel_E, o_br_unsigned_E, o_opa_sel, o_pc_sel, o_mispredict_E}
        !== 7'b0_1_0_1_01_1) begin
      failures++;
      $display("FAIL beq_mispredict got pred/ctr/uns/opa/pcsel/misp=%b exp=0101011",
               {o_pred_taken_F, o_ctr_opa_sel_E, o_br_unsigned_E, o_opa_sel, o_pc_sel, o_mispredict_E});
    end
    idle_e();
  endtask

  // Vector: {f3[2:0], eq, lt, pred, exp_taken, exp_pcsel[1:0], exp_uns, exp_misp}
  task automatic test_resolve();
    logic [10:0] tv [8];
    logic [10:0] v;
    tv = '{11'b111_0_0_1_1_00_1_0,   // BGEU !less, pred taken  -> correct
           11'b100_0_0_1_0_10_0_1,   // BLT  !less, pred taken  -> fall-through
           11'b101_0_1_0_0_00_0_0,   // BGE  less,  pred not    -> correct
           11'b110_0_1_0_1_01_1_1,   // BLTU less,  pred not    -> target
           11'b001_1_0_1_0_10_0_1,   // BNE  equal, pred taken  -> fall-through
           11'b001_0_1_1_1_00_0_0,   // BNE  !equal, pred taken -> correct
           11'b000_0_0_1_0_10_0_1,   // BEQ  !equal, pred taken -> fall-through
           11'b101_1_0_0_1_01_0_1};  // BGE  !less, pred not    -> target
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      v = tv[i];
      @(negedge i_clk);
      drive_e(mk_instr(OPC_BR, v[10:8]), 32'h200, v[7], v[6], v[5], 1'b1, 1'b0);
      #1;
      checks++;
      if ({o_ctr_opa_sel_E, o_opa_sel, o_pc_sel, o_br_unsigned_E, o_mispredict_E}
          !== {1'b1, v[4:0]}) begin
        failures++;
        $display("FAIL resolve[%0d] f3=%b got ctr/opa/pcsel/uns/misp=%b exp=%b", i, v[10:8],
                 {o_ctr_opa_sel_E, o_opa_sel, o_pc_sel, o_br_unsigned_E, o_mispredict_E},
                 {1'b1, v[4:0]});
      end
    end
    idle_e();
  endtask

  task automatic test_bne_train();
    logic tk [9];
    logic ep [9];
    tk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ep = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge i_clk);
      i_pc_F = 32'h40;
      // BNE is taken when not equal.
      drive_e(mk_instr(OPC_BR, 3'b001), 32'h40, ~tk[k], 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (o_pred_taken_F !== ep[k]) begin
        failures++;
        $display("FAIL bne_train step=%0d got=%b exp=%b", k, o_pred_taken_F, ep[k]);
      end
    end
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b1) begin
      failures++;
      $display("FAIL bne_train_final got=%b exp=1", o_pred_taken_F);
    end
  endtask

  task automatic test_rbw_alias();
    apply_reset();
    @(negedge i_clk);
    i_pc_F = 32'h80;
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL rbw_same_cycle got=%b exp=0", o_pred_taken_F);
    end
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b1) begin
      failures++;
      $display("FAIL rbw_after_edge got=%b exp=1", o_pred_taken_F);
    end
    // 0x104 and 0x004 share index 1 (pc[7:2]); 0x008 does not.
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    idle_e();
    i_pc_F = 32'h004;
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b1) begin
      failures++;
      $display("FAIL alias_idx1 got=%b exp=1", o_pred_taken_F);
    end
    i_pc_F = 32'h008;
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL alias_idx2 got=%b exp=0", o_pred_taken_F);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_pc_F = 32'hC0;
      drive_e(mk_instr(OPC_BR, 3'b000), 32'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (o_pred_taken_F !== 1'b0 || o_mispredict_E !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got pred=%b misp=%b exp pred=0 misp=1",
                 k, o_pred_taken_F, o_mispredict_E);
      end
    end
    @(negedge i_clk);
    i_stall_E = 1'b0;
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=%b exp=0", o_pred_taken_F);
    end
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b1) begin
      failures++;
      $display("FAIL stall_single_update got=%b exp=1", o_pred_taken_F);
    end
    // One not-taken update returns to weakly-not-taken only if the release
    // applied exactly one increment.
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b000), 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL stall_once_confirm got=%b exp=0", o_pred_taken_F);
    end
  endtask

  task automatic test_nonbranch_kill();
    logic [31:0] ins [5];
    logic        eqs [5];
    logic        lts [5];
    logic        kls [5];
    logic        sts [5];
    ins = '{mk_instr(OPC_BR, 3'b010), mk_instr(OPC_BR, 3'b011), mk_instr(OPC_BR, 3'b000),
            mk_instr(OPC_BR, 3'b001), mk_instr(OPC_JAL, 3'b000)};
    eqs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    lts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    kls = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    sts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    i_pc_F = 32'h60;
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge i_clk);
        drive_e(ins[k], 32'h60, eqs[k], lts[k], 1'b1, sts[k], kls[k]);
        #1;
        checks++;
        if ({o_ctr_opa_sel_E, o_br_unsigned_E, o_opa_sel, o_pc_sel, o_mispredict_E} !== 6'b0) begin
          failures++;
          $display("FAIL nonbranch[%0d] got=%b exp=000000", k,
                   {o_ctr_opa_sel_E, o_br_unsigned_E, o_opa_sel, o_pc_sel, o_mispredict_E});
        end
      end
    end
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b1) begin
      failures++;
      $display("FAIL nonbranch_bht_kept got=%b exp=1", o_pred_taken_F);
    end
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL nonbranch_bht_exact got=%b exp=0", o_pred_taken_F);
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    @(negedge i_clk);
    i_pc_F = 32'h40;
    drive_e(mk_instr(OPC_BR, 3'b001), 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b1) begin
      failures++;
      $display("FAIL midrun_trained got=%b exp=1", o_pred_taken_F);
    end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL midrun_async_reset got=%b exp=0", o_pred_taken_F);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

`ifdef BR_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    // Stalled mispredicting BEQ, counted once on release.
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge i_clk);
    i_stall_E = 1'b0;
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b001), 32'h304, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // BNE ok
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b100), 32'h308, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // BLT ok
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b101), 32'h30C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // BGE misp
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b111), 32'h310, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // BGEU ok
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b000), 32'h314, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // killed
    @(negedge i_clk);
    drive_e(mk_instr(OPC_BR, 3'b010), 32'h318, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // not a branch
    @(negedge i_clk);
    idle_e();
    #1;
    checks++;
    if (o_br_cnt !== 32'd5 || o_mispred_cnt !== 32'd2) begin
      failures++;
      $display("FAIL perf_counts got br=%0d misp=%0d exp br=5 misp=2", o_br_cnt, o_mispred_cnt);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_br_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset got br=%0d misp=%0d exp 0/0", o_br_cnt, o_mispred_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    i_rst_n = 1'b0;
    i_pc_F  = 32'h0;
    idle_e();
    test_reset();
    test_beq_mispredict();
    test_resolve();
    test_bne_train();
    test_rbw_alias();
    test_stall();
    test_nonbranch_kill();
    test_reset_midrun();
`ifdef BR_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/br_pred_unit.md
BR_PRED_UNIT -- requirements
Module: br_pred_unit

Interface
REQ-001 SHALL provide parameter BHT_DEPTH, default 64, number of BHT entries (power of two, >= 2).
REQ-002 SHALL provide parameter CNT_W, default 2, saturating-counter width (>= 1).
REQ-003 SHALL provide parameter XLEN, default 32, PC and instruction width.
REQ-004 i_clk  in  1  single clock, all state updates on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_pc_F  in  XLEN  fetch-stage PC used for lookup.
REQ-007 o_pred_taken_F  out  1  fetch-stage prediction, combinational from BHT.
REQ-008 i_instr_E  in  XLEN  execute-stage instruction.
REQ-009 i_pc_E  in  XLEN  execute-stage PC used for update index.
REQ-010 i_pred_taken_E  in  1  prediction carried down the pipe with i_instr_E.
REQ-011 i_br_less / i_br_equal  in  1 each  comparator results.
REQ-012 i_stall_E  in  1  execute stage held, suppresses update and counting.
REQ-013 i_kill_E  in  1  execute instruction squashed, treated as non-branch.
REQ-014 o_ctr_opa_sel_E  out  1  high when E holds a valid conditional branch.
REQ-015 o_br_unsigned_E  out  1  comparator unsigned select, equals funct3[1] for branches, else 0.
REQ-016 o_opa_sel  out  1  high when branch resolved taken (ALU operand A = PC for target).
REQ-017 o_pc_sel  out  2  00 no redirect, 01 redirect to ALU target, 10 redirect to i_pc_E+4.
REQ-018 o_mispredict_E  out  1  high when resolved direction differs from i_pred_taken_E.

Function
REQ-019 Valid branch: opcode 1100011, funct3 in {000,001,100,101,110,111}, i_kill_E low; funct3 010/011 SHALL be treated as non-branch with all E outputs 0.
REQ-020 Taken rule: BEQ equal; BNE !equal; BLT/BLTU less; BGE/BGEU !less.
REQ-021 o_mispredict_E = valid & (taken != i_pred_taken_E); o_pc_sel = 01 if mispredict & taken, 10 if mispredict & !taken, else 00.
REQ-022 All E-side outputs SHALL be combinational (zero latency) from E inputs.
REQ-023 BHT index SHALL be pc[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-024 o_pred_taken_F SHALL equal MSB of the indexed counter.
REQ-025 On rising edge with valid branch and i_stall_E low, the indexed counter SHALL increment if taken, decrement if not, saturating at 2^CNT_W-1 and 0.
REQ-026 Same-cycle lookup and update of one index: lookup SHALL return pre-update value (read-before-write).
REQ-027 While i_stall_E high, the same E instruction SHALL update exactly once, on the cycle stall drops.
REQ-028 Kill and stall together: no update.

Reset
REQ-029 Asserting i_rst_n low SHALL immediately set every counter to 2^(CNT_W-1)-1 (weakly not-taken), including mid-operation.
REQ-030 After reset, o_pred_taken_F SHALL be 0 for every PC; E-side outputs depend only on inputs.
REQ-031 Perf counters (when compiled) SHALL reset to 0.

Configuration
REQ-032 Macro BR_PERF_CNT_EN defined: 32-bit outputs o_br_cnt and o_mispred_cnt SHALL count valid unstalled branches and mispredictions, saturating at 0xFFFFFFFF.
REQ-033 Macro BR_PERF_CNT_EN undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-034 Package br_pkg SHALL hold opcode BRANCH constant, funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU), pc_sel enum, and counter-init constant function.
REQ-035 Sub-module br_bht SHALL contain the counter array, async reset, read-before-write port; br_pred_unit holds decode, resolution and perf counters.

Verification
REQ-036 Reset, then lookup pc 0x100 -> o_pred_taken_F=0; BEQ at 0x100 with equal=1, pred=0 -> opa_sel=1, pc_sel=01, mispredict=1.
REQ-037 Three taken BNE updates at 0x40 (CNT_W=2) -> counter 01->10->11->11, o_pred_taken_F=1 from cycle after first update.
REQ-038 BGEU, less=0, pred=1 -> br_unsigned=1, pc_sel=00, mispredict=0; BLT less=0 pred=1 -> pc_sel=10.
REQ-039 Same index lookup and update in one cycle -> pred reflects old counter; stall 3 cycles then release -> single update.
REQ-040 funct3=010 branch opcode, or i_kill_E=1 -> all E outputs 0, BHT unchanged, perf counters unchanged.
REQ-041 BR_PERF_CNT_EN with 5 branches, 2 mispredicted -> o_br_cnt=5, o_mispred_cnt=2; reset mid-run -> both 0.
